// File: rtl/ddr_burst_pkg.sv
// Shared definitions for the DDR burst memory responder.
//  - BEAT_ADDR_STEP / BEAT_SHIFT: burst addresses are in 16-bit units, 8 units per 128-bit beat.
//  - BURST_LEN_W: width of rd_burst_len / wr_burst_len.
//  - burst_state_t: responder FSM states (IDLE, RD, WR, FIN).
//  - burst_fsm_t: the complete FSM state record, kept as one struct so checkers can probe it.
//  - LFSR_SEED / LFSR_TAPS / lfsr_next: stall generator used when BURST_MEM_BACKPRESSURE_EN is defined.
package ddr_burst_pkg;

  localparam int BEAT_ADDR_STEP = 8;
  localparam int BEAT_SHIFT     = $clog2(BEAT_ADDR_STEP);
  localparam int BURST_LEN_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } burst_state_t;

  typedef struct packed {
    burst_state_t           state;
    logic [BURST_LEN_W-1:0] len;        // beats in the accepted burst
    logic [BURST_LEN_W-1:0] issue_cnt;  // read beats sent into the RAM pipeline
    logic [BURST_LEN_W-1:0] beat_cnt;   // beats delivered (read) or requested (write)
  } burst_fsm_t;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting left with feedback into bit 0.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/burst_mem_ram.sv
// Simple dual-port RAM backing the burst responder.
// Ports:
//  clk    in   clock
//  we     in   write enable; wdata is stored at waddr on this edge
//  waddr  in   write beat index
//  wdata  in   write beat
//  raddr  in   read beat index, sampled every edge
//  rdata  out  registered read data, one cycle after raddr
// Contents are not reset.
module burst_mem_ram #(
  parameter int DW = 128,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ddr_burst_mem_responder.sv
// Burst-side stand-in for ddr_controller + MIG: serves rd_burst / wr_burst requests from
// on-chip RAM and models init_calib_complete.
// Ports:
//  clk, rst (async, active high)
//  init_calib_complete  out  rises CALIB_CYCLES edges after reset release, sticky
//  rd_burst_req/len/addr             in   read request (level, held until rd_burst_finish)
//  rd_burst_data_valid/rd_burst_data out  read beats
//  rd_burst_finish                   out  1-cycle pulse at end of read
//  wr_burst_req/len/addr             in   write request (level, held until wr_burst_finish)
//  wr_burst_data_req                 out  initiator drives wr_burst_data in this same cycle
//  wr_burst_data                     in   write beat, captured at the edge closing a req cycle
//  wr_burst_finish                   out  1-cycle pulse at end of write
//  burst_finish                      out  rd_burst_finish | wr_burst_finish
// Configuration macro: BURST_MEM_BACKPRESSURE_EN adds LFSR-driven beat stalls.
//
// Handshake: a request is accepted in an IDLE cycle with calibration done (read wins a tie);
// len/addr are latched then. The responder owns all beat timing: there is no ready from the
// initiator, so every rd_burst_data_valid cycle is a delivered beat and every wr_burst_data_req
// cycle consumes wr_burst_data. After the finish pulse the request must already be low,
// otherwise the next IDLE cycle accepts it as a new burst.
module ddr_burst_mem_responder
  import ddr_burst_pkg::*;
#(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int MEM_AW         = 10,
  parameter int RD_LATENCY     = 4,
  parameter int CALIB_CYCLES   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      init_calib_complete,
  input  logic                      rd_burst_req,
  input  logic [BURST_LEN_W-1:0]    rd_burst_len,
  input  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr,
  output logic                      rd_burst_data_valid,
  output logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
  output logic                      rd_burst_finish,
  input  logic                      wr_burst_req,
  input  logic [BURST_LEN_W-1:0]    wr_burst_len,
  input  logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr,
  output logic                      wr_burst_data_req,
  input  logic [DDR_DATA_WIDTH-1:0] wr_burst_data,
  output logic                      wr_burst_finish,
  output logic                      burst_finish
);

  // RAM read (1) + output register (1) are fixed; the rest of the latency is padding.
  localparam int PAD = RD_LATENCY - 2;
  localparam int CW  = $clog2(CALIB_CYCLES + 1);

  burst_fsm_t          fsm;
  logic [MEM_AW-1:0]   rd_idx;
  logic [MEM_AW-1:0]   wr_idx;
  logic [MEM_AW-1:0]   rd_base;
  logic [MEM_AW-1:0]   wr_base;
  logic [MEM_AW-1:0]   ram_raddr;
  logic [DDR_DATA_WIDTH-1:0] ram_q;
  logic                ram_vld;
  logic                pad_vld;
  logic [DDR_DATA_WIDTH-1:0] pad_data;
  logic                stall;
  logic                accept_rd;
  logic                accept_wr;
  logic                rd_issue;
  logic [BURST_LEN_W-1:0] wr_done_next;
  logic [CW-1:0]       calib_cnt;
  logic                unused_addr_bits;

  assign rd_base = rd_burst_addr[MEM_AW+BEAT_SHIFT-1:BEAT_SHIFT];
  assign wr_base = wr_burst_addr[MEM_AW+BEAT_SHIFT-1:BEAT_SHIFT];
  assign unused_addr_bits = ^{rd_burst_addr[DDR_ADDR_WIDTH-1:MEM_AW+BEAT_SHIFT],
                              rd_burst_addr[BEAT_SHIFT-1:0],
                              wr_burst_addr[DDR_ADDR_WIDTH-1:MEM_AW+BEAT_SHIFT],
                              wr_burst_addr[BEAT_SHIFT-1:0]};

  // ---------------- calibration model ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calib_cnt           <= '0;
      init_calib_complete <= 1'b0;
    end else if (!init_calib_complete) begin
      calib_cnt <= calib_cnt + 1'b1;
      if (calib_cnt == CW'(CALIB_CYCLES - 1)) init_calib_complete <= 1'b1;
    end
  end

  // ---------------- beat stall source ----------------
`ifdef BURST_MEM_BACKPRESSURE_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= lfsr_next(lfsr);
  end
  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  // ---------------- request decode ----------------
  assign accept_rd = (fsm.state == ST_IDLE) && init_calib_complete && rd_burst_req;
  assign accept_wr = (fsm.state == ST_IDLE) && init_calib_complete && !rd_burst_req && wr_burst_req;

  // The first read beat is issued in the accept cycle straight from rd_burst_addr so that the
  // fixed pipeline lands beat 0 exactly RD_LATENCY cycles after accept.
  assign rd_issue = !stall &&
                    ((accept_rd && (rd_burst_len != '0)) ||
                     ((fsm.state == ST_RD) && (fsm.issue_cnt != fsm.len)));
  assign ram_raddr = (fsm.state == ST_IDLE) ? rd_base : rd_idx;

  assign wr_done_next = fsm.beat_cnt + BURST_LEN_W'(wr_burst_data_req);

  burst_mem_ram #(
    .DW (DDR_DATA_WIDTH),
    .AW (MEM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_burst_data_req),
    .waddr (wr_idx),
    .wdata (wr_burst_data),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  // ---------------- read latency padding ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ram_vld <= 1'b0;
    else     ram_vld <= rd_issue;
  end

  generate
    if (PAD == 0) begin : g_no_pad
      assign pad_vld  = ram_vld;
      assign pad_data = ram_q;
    end else begin : g_pad
      logic [PAD-1:0]            v_sr;
      logic [DDR_DATA_WIDTH-1:0] d_sr [PAD];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_sr <= '0;
        end else begin
          v_sr[0] <= ram_vld;
          for (int i = 1; i < PAD; i++) v_sr[i] <= v_sr[i-1];
        end
      end

      always_ff @(posedge clk) begin
        d_sr[0] <= ram_q;
        for (int i = 1; i < PAD; i++) d_sr[i] <= d_sr[i-1];
      end

      assign pad_vld  = v_sr[PAD-1];
      assign pad_data = d_sr[PAD-1];
    end
  endgenerate

  // ---------------- burst FSM with registered outputs ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm.state           <= ST_IDLE;
      fsm.len             <= '0;
      fsm.issue_cnt       <= '0;
      fsm.beat_cnt        <= '0;
      rd_idx              <= '0;
      wr_idx              <= '0;
      rd_burst_data_valid <= 1'b0;
      rd_burst_data       <= '0;
      rd_burst_finish     <= 1'b0;
      wr_burst_data_req   <= 1'b0;
      wr_burst_finish     <= 1'b0;
      burst_finish        <= 1'b0;
    end else begin
      rd_burst_finish     <= 1'b0;
      wr_burst_finish     <= 1'b0;
      burst_finish        <= 1'b0;
      rd_burst_data_valid <= pad_vld;
      if (pad_vld) rd_burst_data <= pad_data;

      case (fsm.state)
        ST_IDLE: begin
          if (accept_rd) begin
            fsm.len       <= rd_burst_len;
            fsm.issue_cnt <= BURST_LEN_W'(rd_issue);
            fsm.beat_cnt  <= '0;
            rd_idx        <= rd_base + MEM_AW'(rd_issue);
            if (rd_burst_len == '0) begin
              fsm.state       <= ST_FIN;
              rd_burst_finish <= 1'b1;
              burst_finish    <= 1'b1;
            end else begin
              fsm.state <= ST_RD;
            end
          end else if (accept_wr) begin
            fsm.len       <= wr_burst_len;
            fsm.issue_cnt <= '0;
            fsm.beat_cnt  <= '0;
            wr_idx        <= wr_base;
            if (wr_burst_len == '0) begin
              fsm.state       <= ST_FIN;
              wr_burst_finish <= 1'b1;
              burst_finish    <= 1'b1;
            end else begin
              fsm.state         <= ST_WR;
              wr_burst_data_req <= !stall;
            end
          end
        end

        ST_RD: begin
          if (rd_issue) begin
            fsm.issue_cnt <= fsm.issue_cnt + 1'b1;
            rd_idx        <= rd_idx + 1'b1;
          end
          if (rd_burst_data_valid) begin
            fsm.beat_cnt <= fsm.beat_cnt + 1'b1;
            // The beat on the outputs now is the last one: finish lands next cycle.
            if (fsm.beat_cnt + 1'b1 == fsm.len) begin
              fsm.state       <= ST_FIN;
              rd_burst_finish <= 1'b1;
              burst_finish    <= 1'b1;
            end
          end
        end

        ST_WR: begin
          if (wr_burst_data_req) begin
            fsm.beat_cnt <= wr_done_next;
            wr_idx       <= wr_idx + 1'b1;
          end
          if (wr_done_next == fsm.len) begin
            wr_burst_data_req <= 1'b0;
            fsm.state         <= ST_FIN;
            wr_burst_finish   <= 1'b1;
            burst_finish      <= 1'b1;
          end else begin
            wr_burst_data_req <= !stall;
          end
        end

        ST_FIN: begin
          fsm.state <= ST_IDLE;
        end

        default: begin
          fsm.state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_burst_mem_responder.sv
// Self-checking bench for ddr_burst_mem_responder: directed vector table, hand-written
// calibration / arbitration / reset sequences, and randomized write-then-read bursts checked
// against a beat-indexed memory model.
module tb_ddr_burst_mem_responder;

  localparam int DW = 128;
  localparam int AWD = 28;
  localparam int DEPTH = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            init_calib_complete;
  logic            rd_burst_req;
  logic [9:0]      rd_burst_len;
  logic [AWD-1:0]  rd_burst_addr;
  logic            rd_burst_data_valid;
  logic [DW-1:0]   rd_burst_data;
  logic            rd_burst_finish;
  logic            wr_burst_req;
  logic [9:0]      wr_burst_len;
  logic [AWD-1:0]  wr_burst_addr;
  logic            wr_burst_data_req;
  logic [DW-1:0]   wr_burst_data;
  logic            wr_burst_finish;
  logic            burst_finish;

  ddr_burst_mem_responder dut (
    .clk                 (clk),
    .rst                 (rst),
    .init_calib_complete (init_calib_complete),
    .rd_burst_req        (rd_burst_req),
    .rd_burst_len        (rd_burst_len),
    .rd_burst_addr       (rd_burst_addr),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_data       (rd_burst_data),
    .rd_burst_finish     (rd_burst_finish),
    .wr_burst_req        (wr_burst_req),
    .wr_burst_len        (wr_burst_len),
    .wr_burst_addr       (wr_burst_addr),
    .wr_burst_data_req   (wr_burst_data_req),
    .wr_burst_data       (wr_burst_data),
    .wr_burst_finish     (wr_burst_finish),
    .burst_finish        (burst_finish)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem_model [DEPTH];
  bit            mem_known [DEPTH];

  logic [DW-1:0] wdata_q [$];  // beats the driver hands out on wr_burst_data_req
  logic [DW-1:0] got_q   [$];  // beats collected from rd_burst_data
  int first_t, fin_t, n_beats, n_fin, n_stray, n_bf_bad;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int min_v);
    n_checks++;
    if (act < min_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected at least %0d", name, act, min_v);
    end
  endtask

  function automatic int beat_index(input logic [AWD-1:0] addr, input int k);
    return ((int'(addr) / 8) + k) % DEPTH;
  endfunction

  // ---------------- driver ----------------
  // Called right after a negedge with the responder idle. Drives the request, services
  // wr_burst_data_req, collects read beats, and returns one cycle after the finish pulse.
  // t counts cycles after the accept cycle.
  task automatic run_burst(input bit is_wr, input int len, input logic [AWD-1:0] addr);
    int budget;
    got_q.delete();
    first_t = -1; fin_t = -1; n_beats = 0; n_fin = 0; n_stray = 0; n_bf_bad = 0;
    budget = 100 + 16 * len;
    if (is_wr) begin
      wr_burst_req = 1'b1; wr_burst_len = 10'(len); wr_burst_addr = addr;
    end else begin
      rd_burst_req = 1'b1; rd_burst_len = 10'(len); rd_burst_addr = addr;
    end
    for (int t = 1; t <= budget; t++) begin
      @(negedge clk);
      if (burst_finish !== (rd_burst_finish | wr_burst_finish)) n_bf_bad++;
      if (is_wr) begin
        if (rd_burst_data_valid || rd_burst_finish) n_stray++;
        if (wr_burst_data_req) begin
          if (first_t < 0) first_t = t;
          wr_burst_data = (n_beats < wdata_q.size()) ? wdata_q[n_beats] : '0;
          n_beats++;
        end
        if (wr_burst_finish) begin
          n_fin++;
          if (fin_t < 0) fin_t = t;
          wr_burst_req = 1'b0;
        end
      end else begin
        if (wr_burst_data_req || wr_burst_finish) n_stray++;
        if (rd_burst_data_valid) begin
          if (first_t < 0) first_t = t;
          got_q.push_back(rd_burst_data);
          n_beats++;
        end
        if (rd_burst_finish) begin
          n_fin++;
          if (fin_t < 0) fin_t = t;
          rd_burst_req = 1'b0;
        end
      end
      if (fin_t > 0 && t >= fin_t + 1) break;
    end
    rd_burst_req = 1'b0;
    wr_burst_req = 1'b0;
  endtask

  task automatic apply_and_check(input string name, input bit is_wr, input int len,
                                 input logic [AWD-1:0] addr, input int exp_first, input int exp_fin);
    int idx;
    run_burst(is_wr, len, addr);
    chk({name, " finish seen"}, logic'(fin_t >= 0), 1'b1);
    chk({name, " beat count"}, n_beats, len);
    chk({name, " finish count"}, n_fin, 1);
    chk({name, " burst_finish"}, n_bf_bad, 0);
    chk({name, " other side quiet"}, n_stray, 0);
`ifdef BURST_MEM_BACKPRESSURE_EN
    chk_ge({name, " first beat"}, first_t, exp_first);
    chk_ge({name, " finish time"}, fin_t, exp_fin);
`else
    chk({name, " first beat"}, first_t, exp_first);
    chk({name, " finish time"}, fin_t, exp_fin);
`endif
    if (is_wr) begin
      for (int k = 0; k < len; k++) begin
        idx = beat_index(addr, k);
        mem_model[idx] = (k < wdata_q.size()) ? wdata_q[k] : '0;
        mem_known[idx] = 1'b1;
      end
    end else begin
      for (int k = 0; k < got_q.size(); k++) begin
        idx = beat_index(addr, k);
        if (mem_known[idx]) chk($sformatf("%s data beat %0d", name, k), got_q[k], mem_model[idx]);
      end
    end
  endtask

  // Called right after reset release at a negedge; checks the calibration rise point.
  task automatic wait_calib(input string name);
    int  rise_n;
    bit  dropped;
    rise_n = -1;
    dropped = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (init_calib_complete && rise_n < 0) rise_n = n;
      if (!init_calib_complete && rise_n >= 0) dropped = 1'b1;
    end
    chk({name, " calib rise cycle"}, rise_n, 64);
    chk({name, " calib sticky"}, dropped, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            is_wr;
    int            len;
    logic [AWD-1:0] addr;
    logic [DW-1:0] dbase;      // write data = dbase + beat number
    int            exp_first;  // cycles after accept to first valid / req (-1: none)
    int            exp_fin;    // cycles after accept to finish pulse
  } vec_t;

  vec_t vecs [10];

  // ---------------- main sequence ----------------
  initial begin
    int rise_n, fin_n, nb;
    int rd_ft, wr_ft, wr_first, nrd, nwr, nbf, len, off;
    logic [AWD-1:0] addr;
    bit dropped;

    vecs[0] = '{1'b1, 4, 28'h40,   128'h1,   1, 5};
    vecs[1] = '{1'b0, 4, 28'h40,   128'h0,   4, 8};
    vecs[2] = '{1'b1, 3, 28'h1FF8, 128'h100, 1, 4};
    vecs[3] = '{1'b0, 2, 28'h0,    128'h0,   4, 6};
    vecs[4] = '{1'b0, 1, 28'h1FF8, 128'h0,   4, 5};
    vecs[5] = '{1'b0, 0, 28'h40,   128'h0,  -1, 1};
    vecs[6] = '{1'b1, 0, 28'h40,   128'hEE, -1, 1};
    vecs[7] = '{1'b0, 4, 28'h47,   128'h0,   4, 8};
    vecs[8] = '{1'b1, 1, 28'h2040, 128'h55,  1, 2};
    vecs[9] = '{1'b0, 2, 28'h40,   128'h0,   4, 6};

    for (int i = 0; i < DEPTH; i++) mem_known[i] = 1'b0;

    rst = 1'b1;
    rd_burst_req = 1'b0; rd_burst_len = '0; rd_burst_addr = '0;
    wr_burst_req = 1'b0; wr_burst_len = '0; wr_burst_addr = '0;
    wr_burst_data = '0;

    repeat (3) @(negedge clk);
    chk("reset calib", init_calib_complete, 1'b0);
    chk("reset rd valid", rd_burst_data_valid, 1'b0);
    chk("reset rd data", rd_burst_data, '0);
    chk("reset rd finish", rd_burst_finish, 1'b0);
    chk("reset wr req", wr_burst_data_req, 1'b0);
    chk("reset wr finish", wr_burst_finish, 1'b0);
    chk("reset burst_finish", burst_finish, 1'b0);
    rst = 1'b0;

    // Calibration window; a read requested at cycle 10 must wait for it.
    rise_n = -1; fin_n = -1; dropped = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (init_calib_complete && rise_n < 0) rise_n = n;
      if (!init_calib_complete && rise_n >= 0) dropped = 1'b1;
      if (rd_burst_finish && fin_n < 0) begin
        fin_n = n;
        rd_burst_req = 1'b0;
      end
      if (n == 10) begin
        rd_burst_req = 1'b1; rd_burst_len = '0; rd_burst_addr = 28'h40;
      end
    end
    chk("calib rise cycle", rise_n, 64);
    chk("calib sticky", dropped, 1'b0);
    chk("early req finish cycle", fin_n, 65);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      wdata_q.delete();
      for (int k = 0; k < vecs[i].len; k++) wdata_q.push_back(vecs[i].dbase + DW'(k));
      apply_and_check($sformatf("vec%0d", i), vecs[i].is_wr, vecs[i].len, vecs[i].addr,
                      vecs[i].exp_first, vecs[i].exp_fin);
    end

    // Simultaneous read and write requests: read first, then write.
    wdata_q.delete();
    wdata_q.push_back(128'hA1);
    wdata_q.push_back(128'hA2);
    got_q.delete();
    rd_ft = -1; wr_ft = -1; wr_first = -1; nrd = 0; nwr = 0; nbf = 0;
    rd_burst_req = 1'b1; rd_burst_len = 10'd2; rd_burst_addr = 28'h40;
    wr_burst_req = 1'b1; wr_burst_len = 10'd2; wr_burst_addr = 28'h80;
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      if (burst_finish) nbf++;
      if (rd_burst_data_valid) begin
        got_q.push_back(rd_burst_data);
        nrd++;
      end
      if (wr_burst_data_req) begin
        if (wr_first < 0) wr_first = t;
        wr_burst_data = (nwr < 2) ? wdata_q[nwr] : '0;
        nwr++;
      end
      if (rd_burst_finish && rd_ft < 0) begin
        rd_ft = t;
        rd_burst_req = 1'b0;
      end
      if (wr_burst_finish && wr_ft < 0) begin
        wr_ft = t;
        wr_burst_req = 1'b0;
      end
      if (wr_ft > 0 && t >= wr_ft + 1) break;
    end
    rd_burst_req = 1'b0;
    wr_burst_req = 1'b0;
    chk("both req finish pulses", nbf, 2);
    chk("both req read beats", nrd, 2);
    chk("both req write beats", nwr, 2);
    chk("both req read before write", logic'(rd_ft >= 0 && wr_first > rd_ft), 1'b1);
`ifndef BURST_MEM_BACKPRESSURE_EN
    chk("both req read finish", rd_ft, 6);
    chk("both req write finish", wr_ft, 10);
`endif
    for (int k = 0; k < got_q.size(); k++)
      chk($sformatf("both req read data %0d", k), got_q[k], mem_model[beat_index(28'h40, k)]);
    for (int k = 0; k < 2; k++) begin
      mem_model[beat_index(28'h80, k)] = wdata_q[k];
      mem_known[beat_index(28'h80, k)] = 1'b1;
    end
    apply_and_check("both req readback", 1'b0, 2, 28'h80, 4, 6);

    // Randomized write-then-read bursts at arbitrary addresses.
    for (int i = 0; i < 10; i++) begin
      len  = (i == 0) ? 16 : int'($urandom_range(1, 20));
      addr = AWD'($urandom);
      wdata_q.delete();
      for (int k = 0; k < len; k++) wdata_q.push_back({$urandom, $urandom, $urandom, $urandom});
      apply_and_check($sformatf("rand%0d wr", i), 1'b1, len, addr, 1, len + 1);
      off = (i == 0) ? 0 : int'($urandom_range(0, len - 1));
      apply_and_check($sformatf("rand%0d rd", i), 1'b0, len - off, addr + AWD'(8 * off),
                      4, 4 + len - off);
    end

    // Reset during the third beat of an 8-beat read.
    nb = 0;
    rd_burst_req = 1'b1; rd_burst_len = 10'd8; rd_burst_addr = 28'h40;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      if (rd_burst_data_valid) nb++;
      if (nb == 3) break;
    end
    chk("midrst third beat reached", nb, 3);
    rst = 1'b1;
    rd_burst_req = 1'b0;
    @(negedge clk);
    chk("midrst calib", init_calib_complete, 1'b0);
    chk("midrst rd valid", rd_burst_data_valid, 1'b0);
    chk("midrst rd data", rd_burst_data, '0);
    chk("midrst rd finish", rd_burst_finish, 1'b0);
    chk("midrst wr req", wr_burst_data_req, 1'b0);
    chk("midrst wr finish", wr_burst_finish, 1'b0);
    chk("midrst burst_finish", burst_finish, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    wait_calib("recal");

    // RAM keeps its contents across reset.
    apply_and_check("post reset read", 1'b0, 4, 28'h40, 4, 8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
